sample_in_ball_sampler: RTL and testbench
=========================================

Name: sample_in_ball_sampler

Overview:
- Front end of SampleInBall. Consumes the SHAKE256 squeeze stream word by word.
- Captures the first 64-bit word as the sign vector.
- Runs byte rejection sampling per FIPS 204 to produce one (i, j, sign) swap command per accepted byte for the downstream shuffler.
- Sits between the Keccak squeeze output and the shuffler's valid/hold input.

Parameters:
- SIB_TAU, 60: number of nonzero coefficients (39/49/60). Legal range 1..64.
- SIB_SAMPLE_W, 8: index and sample byte width.
- DATA_W, 64: squeeze word width. Fixed at 64.

Ports:
- clk  input  1  clock
- rst_b  input  1  reset; asynchronous, active-low
- zeroize  input  1  synchronous clear of all state, highest priority after reset
- start_i  input  1  one-cycle pulse; begins a new sampling run
- data_i  input  64  squeeze word; byte k is data_i[8k+7:8k], consumed k=0 first
- data_valid_i  input  1  squeeze word valid
- data_ready_o  output  1  sampler accepts data_i this cycle
- valid_o  output  1  swap command valid
- hold_i  input  1  downstream not accepting; command transfers on valid_o & ~hold_i
- indexi_o  output  8  current i (256-SIB_TAU .. 255)
- indexj_o  output  8  accepted sample byte j
- sign_o  output  1  sign bit for this command
- busy_o  output  1  run in progress
- done_o  output  1  one-cycle pulse after final command transfers

Behaviour:
- Reset (rst_b low) and zeroize:
  - state=IDLE; all registers cleared.
  - Outputs: data_ready_o=0, valid_o=0, indexi_o=0, indexj_o=0, sign_o=0, busy_o=0, done_o=0.
- Registers:
  - sign_q[63:0]
  - buf_q[63:0], buf_vld
  - ptr[2:0] (byte pointer)
  - i_q[7:0]
  - k_q[5:0] (sign index = i_q - (256-SIB_TAU))
- State IDLE:
  - start_i -> SIGN; i_q=256-SIB_TAU, k_q=0, buf_vld=0.
  - start_i is ignored in every other state.
- State SIGN:
  - data_ready_o=1.
  - On data_valid_i: sign_q<=data_i, then go to SAMPLE.
  - The sign word is never used as sample bytes.
- State SAMPLE, buffer empty (buf_vld=0):
  - data_ready_o=1.
  - On data_valid_i: buf_q<=data_i, ptr=0, buf_vld=1.
  - No byte is evaluated in the load cycle, so there is one bubble per word.
- State SAMPLE, buffer full (buf_vld=1): byte b = buf_q[8*ptr +: 8].
  - b > i_q (reject):
    - valid_o=0; ptr advances in 1 cycle.
    - Rejected bytes are never presented.
  - b <= i_q (accept; b == i_q is accepted):
    - valid_o=1, indexi_o=i_q, indexj_o=b, sign_o=sign_q[k_q], all combinational from registers.
    - While hold_i=1: all outputs held stable, nothing advances.
    - On ~hold_i: ptr advances; i_q and k_q increment.
  - ptr wrap 7->0 clears buf_vld. A new word is requested next cycle.
  - data_ready_o=0 while buf_vld=1.
- Termination:
  - Transfer of the command with i_q==255 -> state DONE.
  - Unconsumed bytes in buf_q are discarded and buf_vld is cleared.
  - No further data_ready_o.
  - The i_q increment past 255 is suppressed; i_q never wraps.
- State DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o=1 in SIGN and SAMPLE; 0 in IDLE and DONE.
- Downstream shuffler: holds the first cycle of each command, so each accepted byte costs 2 cycles and each rejected byte costs 1.
- data_valid_i low: stall with no side effects; valid_o stays 0 while the buffer is empty.
- Reset or zeroize mid-run: immediately IDLE.
  - valid_o drops the same cycle for zeroize, asynchronously for rst_b.
  - The sign vector and buffer are cleared.
  - No done_o.
- Sign bits sign_q[63:SIB_TAU] are ignored.

Test Plan:
- Normal run: SIB_TAU=60, sign word 64'hFFFF_FFFF_FFFF_FFFF, all sample bytes 0, hold_i toggling 1,0 per command.
  - Expect 60 commands: indexi 196..255, indexj=0, sign=1 each.
  - done_o pulses once; 8 sample words consumed.
- Reject and equality boundary: sign word 0, first sample bytes 200, 255, 196, ...
  - 200 and 255 are rejected with no valid_o.
  - 196 is accepted as (i=196, j=196, sign=0); next command has i=197.
- Sign mapping: sign word 64'h1 with bit 59 set, bytes all 0.
  - sign_o=1 only for i=196 and i=255; all others 0.
- Hold stability: hold_i held high 5 cycles on the first command.
  - indexi_o, indexj_o, sign_o and valid_o stay constant.
  - data_ready_o stays 0; no byte consumed.
- Stream stall and early end: data_valid_i low 10 cycles between words.
  - No spurious valid_o.
  - Final command in mid-word: remaining bytes are discarded, no further data_ready_o, done_o one cycle later.
- Zeroize mid-run after 30 commands: all outputs 0 next cycle, busy_o=0, no done_o.
  - A new start_i restarts at i=196 and requests a fresh sign word.

Source files
------------

// File: rtl/sample_in_ball_sampler.sv
// SampleInBall front end: captures the 64-bit sign word from the SHAKE256 squeeze
// stream, then rejection-samples bytes into (i, j, sign) swap commands for the shuffler.
module sample_in_ball_sampler #(
  parameter int SIB_TAU      = 60,
  parameter int SIB_SAMPLE_W = 8,
  parameter int DATA_W       = 64
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    zeroize,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic                    valid_o,
  input  logic                    hold_i,
  output logic [SIB_SAMPLE_W-1:0] indexi_o,
  output logic [SIB_SAMPLE_W-1:0] indexj_o,
  output logic                    sign_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int BYTES = DATA_W / SIB_SAMPLE_W;
  localparam int PTR_W = $clog2(BYTES);
  localparam int K_W   = $clog2(DATA_W);
  localparam logic [SIB_SAMPLE_W-1:0] I_START  = SIB_SAMPLE_W'(256 - SIB_TAU);
  localparam logic [SIB_SAMPLE_W-1:0] I_LAST   = '1;
  localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, SIGN, SAMPLE, DONE} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       sign_q;
  logic [DATA_W-1:0]       buf_q;
  logic                    buf_vld;
  logic [PTR_W-1:0]        ptr;
  logic [SIB_SAMPLE_W-1:0] i_q;
  logic [K_W-1:0]          k_q;

  logic [SIB_SAMPLE_W-1:0] cur_byte;
  logic                    accept;
  logic                    cmd_vld;
  logic                    byte_last;

  always_comb begin
    cur_byte  = buf_q[32'(ptr) * SIB_SAMPLE_W +: SIB_SAMPLE_W];
    accept    = (cur_byte <= i_q);
    byte_last = (ptr == PTR_LAST);
    cmd_vld   = (state == SAMPLE) && buf_vld && accept;
  end

  // Command fields come straight from registers; zeroize masks them in the same cycle.
  always_comb begin
    valid_o      = cmd_vld && !zeroize;
    data_ready_o = !zeroize && ((state == SIGN) || ((state == SAMPLE) && !buf_vld));
    indexi_o     = valid_o ? i_q : '0;
    indexj_o     = valid_o ? cur_byte : '0;
    sign_o       = valid_o && sign_q[k_q];
    busy_o       = (state == SIGN) || (state == SAMPLE);
    done_o       = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      sign_q  <= '0;
      buf_q   <= '0;
      buf_vld <= 1'b0;
      ptr     <= '0;
      i_q     <= '0;
      k_q     <= '0;
    end else if (zeroize) begin
      state   <= IDLE;
      sign_q  <= '0;
      buf_q   <= '0;
      buf_vld <= 1'b0;
      ptr     <= '0;
      i_q     <= '0;
      k_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= SIGN;
            i_q     <= I_START;
            k_q     <= '0;
            ptr     <= '0;
            buf_vld <= 1'b0;
          end
        end
        SIGN: begin
          if (data_valid_i) begin
            sign_q <= data_i;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (!buf_vld) begin
            // Load-only cycle: the fresh word is evaluated starting next cycle.
            if (data_valid_i) begin
              buf_q   <= data_i;
              ptr     <= '0;
              buf_vld <= 1'b1;
            end
          end else if (!accept) begin
            ptr <= ptr + 1'b1;
            if (byte_last) buf_vld <= 1'b0;
          end else if (!hold_i) begin
            if (i_q == I_LAST) begin
              // Final command: drop any bytes left in the buffer, never wrap i.
              state   <= DONE;
              buf_vld <= 1'b0;
            end else begin
              i_q <= i_q + 1'b1;
              k_q <= k_q + 1'b1;
              ptr <= ptr + 1'b1;
              if (byte_last) buf_vld <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_in_ball_sampler.sv
// Randomized bench for sample_in_ball_sampler, checked against a byte-level
// SampleInBall rejection-sampling reference model.
module tb_sample_in_ball_sampler;
  localparam int TAU = 60;
  localparam int I0  = 256 - TAU;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        zeroize = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        data_ready_o, valid_o, sign_o, busy_o, done_o;
  logic [7:0]  indexi_o, indexj_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sample_in_ball_sampler #(.SIB_TAU(TAU), .SIB_SAMPLE_W(8), .DATA_W(64)) dut (
    .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start_i(start_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .valid_o(valid_o), .hold_i(hold_i), .indexi_o(indexi_o), .indexj_o(indexj_o),
    .sign_o(sign_o), .busy_o(busy_o), .done_o(done_o)
  );

  logic [63:0] stim_words[$];
  int exp_i[$], exp_j[$], exp_s[$];
  int exp_words;
  int obs_i[$], obs_j[$], obs_s[$];
  int words_consumed, done_count, hold_viol, overlap;
  int ready_after_final, valid_after_final, done_lat, xfer_cyc, timeout;

  // Reference: walk the sample bytes in stream order, accept b <= i, stop once i passes 255.
  task automatic model_run(input logic [63:0] sw);
    int i, w, b, v;
    logic [63:0] wv;
    exp_i.delete(); exp_j.delete(); exp_s.delete();
    i = I0; w = 0; b = 0; exp_words = 1;
    while (i <= 255 && w < stim_words.size()) begin
      wv = stim_words[w];
      v = int'(wv[8*b +: 8]);
      if (v <= i) begin
        exp_i.push_back(i);
        exp_j.push_back(v);
        exp_s.push_back(int'(sw[i - I0]));
        i++;
      end
      exp_words = w + 2;
      b++;
      if (b == 8) begin b = 0; w++; end
    end
  endtask

  task automatic fill_words(input int kind);
    stim_words.delete();
    for (int n = 0; n < 40; n++)
      stim_words.push_back(kind == 0 ? 64'd0 : {$urandom, $urandom});
  endtask

  function automatic int pick_hold(input int mode);
    return (mode == 1) ? int'($urandom_range(0, 2)) : 1;
  endfunction

  // Drives one run from a start pulse; records transferred commands and protocol counters.
  task automatic run_stream(input logic [63:0] sw, input int hold_mode, input int stall_len,
                            input int max_cmds, input bit rand_start);
    int widx, stall, hcnt, htarget, post, cyc;
    logic [7:0] li, lj;
    logic ls;
    bit finished;
    obs_i.delete(); obs_j.delete(); obs_s.delete();
    words_consumed = 0; done_count = 0; hold_viol = 0; overlap = 0;
    ready_after_final = 0; valid_after_final = 0; done_lat = -1; xfer_cyc = 0; timeout = 0;
    li = '0; lj = '0; ls = 1'b0;
    @(negedge clk); start_i = 1'b1; data_valid_i = 1'b0; hold_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    widx = 0; stall = 0; hcnt = 0; post = 0; cyc = 0; finished = 0;
    htarget = (hold_mode == 2) ? 5 : pick_hold(hold_mode);
    while (1) begin
      cyc++;
      if (cyc > 5000) begin timeout = 1; break; end
      if (done_o) begin
        done_count++;
        if (done_count == 1) done_lat = cyc - xfer_cyc;
      end
      if (finished) begin
        if (data_ready_o) ready_after_final++;
        if (valid_o) valid_after_final++;
        post++;
        if (post == 5) break;
      end
      if (valid_o && data_ready_o) overlap++;
      if (stall > 0) begin
        data_valid_i = 1'b0;
        stall--;
      end else begin
        data_valid_i = 1'b1;
        if (widx == 0) data_i = sw;
        else if (widx - 1 < stim_words.size()) data_i = stim_words[widx - 1];
        else data_i = {$urandom, $urandom};
        if (data_ready_o) begin words_consumed++; widx++; stall = stall_len; end
      end
      hold_i = 1'b0;
      if (valid_o) begin
        if (hcnt > 0 && (indexi_o !== li || indexj_o !== lj || sign_o !== ls)) hold_viol++;
        if (hcnt == 0) begin li = indexi_o; lj = indexj_o; ls = sign_o; end
        if (hcnt < htarget) begin
          hold_i = 1'b1;
          hcnt++;
        end else begin
          obs_i.push_back(int'(indexi_o));
          obs_j.push_back(int'(indexj_o));
          obs_s.push_back(int'(sign_o));
          hcnt = 0;
          htarget = pick_hold(hold_mode);
          if (indexi_o == 8'd255) begin finished = 1; xfer_cyc = cyc; end
        end
      end else if (hcnt > 0) begin
        hold_viol++;
      end
      start_i = rand_start && busy_o && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (max_cmds > 0 && obs_i.size() >= max_cmds) break;
    end
    start_i = 1'b0; data_valid_i = 1'b0; hold_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({data_ready_o, valid_o, indexi_o, indexj_o, sign_o, busy_o, done_o} !== 21'd0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b vld=%b i=%0d j=%0d s=%b busy=%b done=%b required all 0",
               data_ready_o, valid_o, indexi_o, indexj_o, sign_o, busy_o, done_o);
    end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({data_ready_o, valid_o, busy_o, done_o} !== 4'd0) begin
      fails++;
      $display("FAIL idle_after_reset got rdy=%b vld=%b busy=%b done=%b required 0",
               data_ready_o, valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_normal();
    fill_words(0);
    model_run(64'hFFFF_FFFF_FFFF_FFFF);
    run_stream(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    tests++;
    if (obs_i.size() !== 60 || timeout !== 0) begin
      fails++;
      $display("FAIL normal_count got %0d (timeout=%0d) required 60", obs_i.size(), timeout);
    end
    for (int n = 0; n < 60 && n < obs_i.size(); n++) begin
      tests++;
      if (obs_i[n] !== 196 + n || obs_j[n] !== 0 || obs_s[n] !== 1) begin
        fails++;
        $display("FAIL normal_cmd[%0d] got i=%0d j=%0d s=%0d required i=%0d j=0 s=1",
                 n, obs_i[n], obs_j[n], obs_s[n], 196 + n);
      end
    end
    tests++;
    if (done_count !== 1 || done_lat !== 1) begin
      fails++;
      $display("FAIL normal_done got count=%0d latency=%0d required 1/1", done_count, done_lat);
    end
    tests++;
    if (words_consumed !== 9 || exp_words !== 9) begin
      fails++;
      $display("FAIL normal_words got %0d (model %0d) required 9 (sign + 8)", words_consumed, exp_words);
    end
    tests++;
    if (ready_after_final !== 0 || valid_after_final !== 0 || overlap !== 0 || hold_viol !== 0) begin
      fails++;
      $display("FAIL normal_protocol got rdy_after=%0d vld_after=%0d overlap=%0d hold_viol=%0d required 0",
               ready_after_final, valid_after_final, overlap, hold_viol);
    end
  endtask

  task automatic test_reject_boundary();
    fill_words(1);
    stim_words[0] = 64'h0000_0000_00C4_FFC8;
    model_run(64'd0);
    run_stream(64'd0, 0, 0, 0, 0);
    tests++;
    if (obs_i.size() < 2 || obs_i[0] !== 196 || obs_j[0] !== 196 || obs_s[0] !== 0 ||
        obs_i[1] !== 197 || obs_j[1] !== 0) begin
      fails++;
      $display("FAIL reject_first got n=%0d i0=%0d j0=%0d s0=%0d i1=%0d j1=%0d required (196,196,0),(197,0)",
               obs_i.size(), obs_size_i(0), obs_size_j(0), obs_size_s(0), obs_size_i(1), obs_size_j(1));
    end
    tests++;
    if (obs_i.size() !== exp_i.size() || timeout !== 0) begin
      fails++;
      $display("FAIL reject_count got %0d required %0d", obs_i.size(), exp_i.size());
    end
    for (int n = 0; n < exp_i.size() && n < obs_i.size(); n++) begin
      tests++;
      if (obs_i[n] !== exp_i[n] || obs_j[n] !== exp_j[n] || obs_s[n] !== exp_s[n]) begin
        fails++;
        $display("FAIL reject_cmd[%0d] got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 n, obs_i[n], obs_j[n], obs_s[n], exp_i[n], exp_j[n], exp_s[n]);
      end
    end
  endtask

  function automatic int obs_size_i(input int n);
    return (n < obs_i.size()) ? obs_i[n] : -1;
  endfunction
  function automatic int obs_size_j(input int n);
    return (n < obs_j.size()) ? obs_j[n] : -1;
  endfunction
  function automatic int obs_size_s(input int n);
    return (n < obs_s.size()) ? obs_s[n] : -1;
  endfunction

  task automatic test_sign_map();
    int want;
    fill_words(0);
    run_stream(64'hF800_0000_0000_0001, 1, 0, 0, 0);
    tests++;
    if (obs_i.size() !== 60) begin
      fails++;
      $display("FAIL sign_count got %0d required 60", obs_i.size());
    end
    for (int n = 0; n < obs_i.size(); n++) begin
      want = (obs_i[n] == 196 || obs_i[n] == 255) ? 1 : 0;
      tests++;
      if (obs_s[n] !== want || obs_i[n] !== 196 + n) begin
        fails++;
        $display("FAIL sign_map[%0d] got i=%0d s=%0d required i=%0d s=%0d",
                 n, obs_i[n], obs_s[n], 196 + n, want);
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] sw;
    fill_words(1);
    sw = {$urandom, $urandom};
    model_run(sw);
    run_stream(sw, 2, 0, 0, 0);
    tests++;
    if (hold_viol !== 0 || overlap !== 0) begin
      fails++;
      $display("FAIL hold_stable got hold_viol=%0d ready_with_valid=%0d required 0", hold_viol, overlap);
    end
    tests++;
    if (obs_i.size() !== exp_i.size() || words_consumed !== exp_words) begin
      fails++;
      $display("FAIL hold_run got cmds=%0d words=%0d required cmds=%0d words=%0d",
               obs_i.size(), words_consumed, exp_i.size(), exp_words);
    end
    for (int n = 0; n < exp_i.size() && n < obs_i.size(); n++) begin
      tests++;
      if (obs_i[n] !== exp_i[n] || obs_j[n] !== exp_j[n] || obs_s[n] !== exp_s[n]) begin
        fails++;
        $display("FAIL hold_cmd[%0d] got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 n, obs_i[n], obs_j[n], obs_s[n], exp_i[n], exp_j[n], exp_s[n]);
      end
    end
  endtask

  task automatic test_stall_random(input int runs, input int stall_len, input int hold_mode);
    logic [63:0] sw;
    int bad;
    for (int r = 0; r < runs; r++) begin
      fill_words(1);
      sw = {$urandom, $urandom};
      model_run(sw);
      run_stream(sw, hold_mode, (stall_len < 0) ? int'($urandom_range(0, 3)) : stall_len, 0, 1);
      bad = 0;
      for (int n = 0; n < exp_i.size() && n < obs_i.size(); n++)
        if (obs_i[n] !== exp_i[n] || obs_j[n] !== exp_j[n] || obs_s[n] !== exp_s[n]) bad++;
      tests++;
      if (bad !== 0 || obs_i.size() !== exp_i.size() || timeout !== 0) begin
        fails++;
        $display("FAIL stream_cmds run %0d got %0d bad of %0d cmds (timeout=%0d) required 0 bad of %0d",
                 r, bad, obs_i.size(), timeout, exp_i.size());
      end
      tests++;
      if (words_consumed !== exp_words || done_count !== 1 || done_lat !== 1) begin
        fails++;
        $display("FAIL stream_end run %0d got words=%0d done=%0d lat=%0d required words=%0d done=1 lat=1",
                 r, words_consumed, done_count, done_lat, exp_words);
      end
      tests++;
      if (ready_after_final !== 0 || valid_after_final !== 0 || overlap !== 0 || hold_viol !== 0) begin
        fails++;
        $display("FAIL stream_protocol run %0d got rdy_after=%0d vld_after=%0d overlap=%0d hold_viol=%0d required 0",
                 r, ready_after_final, valid_after_final, overlap, hold_viol);
      end
    end
  endtask

  task automatic test_zeroize();
    int dones;
    logic [63:0] sw;
    fill_words(0);
    run_stream(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 30, 0);
    zeroize = 1'b1;
    #1;
    tests++;
    if (valid_o !== 1'b0 || data_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL zeroize_same_cycle got vld=%b rdy=%b required 0", valid_o, data_ready_o);
    end
    @(negedge clk);
    zeroize = 1'b0;
    tests++;
    if ({data_ready_o, valid_o, indexi_o, indexj_o, sign_o, busy_o, done_o} !== 21'd0) begin
      fails++;
      $display("FAIL zeroize_outputs got rdy=%b vld=%b i=%0d j=%0d s=%b busy=%b done=%b required all 0",
               data_ready_o, valid_o, indexi_o, indexj_o, sign_o, busy_o, done_o);
    end
    dones = 0;
    repeat (6) begin @(negedge clk); if (done_o || busy_o) dones++; end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL zeroize_no_done got %0d done/busy cycles required 0", dones);
    end
    fill_words(1);
    sw = {$urandom, $urandom};
    model_run(sw);
    run_stream(sw, 1, 0, 0, 0);
    tests++;
    if (obs_i.size() !== exp_i.size() || obs_size_i(0) !== 196 || words_consumed !== exp_words ||
        done_count !== 1) begin
      fails++;
      $display("FAIL zeroize_restart got cmds=%0d i0=%0d words=%0d done=%0d required cmds=%0d i0=196 words=%0d done=1",
               obs_i.size(), obs_size_i(0), words_consumed, done_count, exp_i.size(), exp_words);
    end
    for (int n = 0; n < exp_i.size() && n < obs_i.size(); n++) begin
      tests++;
      if (obs_i[n] !== exp_i[n] || obs_j[n] !== exp_j[n] || obs_s[n] !== exp_s[n]) begin
        fails++;
        $display("FAIL restart_cmd[%0d] got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 n, obs_i[n], obs_j[n], obs_s[n], exp_i[n], exp_j[n], exp_s[n]);
      end
    end
  endtask

  task automatic test_async_reset();
    int dones;
    fill_words(0);
    run_stream(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 10, 0);
    #2 rst_b = 1'b0;
    #1;
    tests++;
    if ({data_ready_o, valid_o, indexi_o, indexj_o, sign_o, busy_o, done_o} !== 21'd0) begin
      fails++;
      $display("FAIL async_reset got rdy=%b vld=%b i=%0d busy=%b done=%b required all 0",
               data_ready_o, valid_o, indexi_o, busy_o, done_o);
    end
    @(negedge clk);
    rst_b = 1'b1;
    dones = 0;
    repeat (4) begin @(negedge clk); if (done_o || busy_o) dones++; end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL async_reset_idle got %0d done/busy cycles required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_reject_boundary();
    test_sign_map();
    test_hold();
    test_stall_random(2, 10, 0);
    test_stall_random(4, -1, 1);
    test_zeroize();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
